bp_cfg_loader: RTL
==================

Name: bp_cfg_loader

Overview:
- Post-reset configuration sequencer. It consumes the per-system processor parameters (core count, CCE microcode depth) that the aviary package selects.
- For every core it issues a stream of config-bus writes: freeze, core id, CCE microcode, CCE mode. It then unfreezes all cores and asserts done.
- Sits between the top-level reset/clock domain and the per-tile config link.

Parameters:
- num_core_p, 1, number of cores to configure (cc_x_dim*cc_y_dim); ≥1.
- cce_pc_width_p, 8, microcode address width; ucode depth = 2**cce_pc_width_p.
- cfg_addr_width_p, 16, config-bus address width.
- cfg_data_width_p, 64, config-bus data width; also the microcode word width.
- skip_ucode_p, 0, 1 = omit the microcode phase and leave CCE mode uncached.

Ports:
- clk_i  in  1  clock.
- reset_i  in  1  synchronous active-high reset.
- cfg_v_o  out  1  config write valid.
- cfg_ready_i  in  1  config link ready; a transfer occurs on cfg_v_o & cfg_ready_i.
- cfg_core_o  out  max(1,clog2(num_core_p))  destination core id.
- cfg_addr_o  out  cfg_addr_width_p  config register address.
- cfg_data_o  out  cfg_data_width_p  write data.
- ucode_addr_o  out  cce_pc_width_p  microcode ROM read address.
- ucode_data_i  in  cfg_data_width_p  ROM data; valid exactly 1 cycle after ucode_addr_o.
- done_o  out  1  sequence complete; sticky until reset.

Behaviour:
- Reset (any cycle, including mid-sequence): state=e_reset, all counters 0. Outputs cfg_v_o=0, done_o=0, cfg_core_o=0, cfg_addr_o=0, cfg_data_o=0, ucode_addr_o=0.
- Handshake: once cfg_v_o=1, cfg_core_o, cfg_addr_o and cfg_data_o hold stable until cfg_ready_i. cfg_v_o never depends combinationally on cfg_ready_i. At most one write per cycle.
- FSM, with core counter c:
  - e_reset: unconditionally → e_freeze next cycle.
  - e_freeze: write addr=freeze_addr, data=1 → e_core_id on handshake.
  - e_core_id: write addr=core_id_addr, data=c (zero-extended) → e_ucode_fetch on handshake, or → e_mode if skip_ucode_p.
  - e_ucode_fetch: cfg_v_o=0; ucode_addr_o=u → e_ucode_write.
  - e_ucode_write: cfg_data_o = word captured from ucode_data_i; addr=ucode_base_addr+u. On handshake: if u=max, then u←0 and → e_mode; else u++ and → e_ucode_fetch.
  - e_mode: write addr=cce_mode_addr, data=e_cce_mode_normal (or e_cce_mode_uncached if skip_ucode_p) → e_next_core on handshake.
  - e_next_core: if c=num_core_p-1, then c←0 and → e_unfreeze; else c++ and → e_freeze.
  - e_unfreeze: write addr=freeze_addr, data=0 to core c. On handshake: if last core → e_done, else c++.
  - e_done: cfg_v_o=0, done_o=1; absorbing state.
- Word counts:
  - Microcode word throughput: 2 cycles/word with ready held high.
  - Writes per core: 3+2**cce_pc_width_p (3 if skip). Plus num_core_p unfreeze writes.
  - Total writes = num_core_p*(4+2**cce_pc_width_p) (4 if skip).
- Wrap rules:
  - u wraps to 0 only via the max check, never by overflow.
  - cfg_core_o = c for every write.
- Back-pressure of any length (including ready low forever) must not alter the sequence, only stall it.

Decomposition:
- Shared package bp_cfg_loader_pkg holds:
  - Address constants: freeze_addr=16'h0002, core_id_addr=16'h0004, cce_mode_addr=16'h0006, ucode_base_addr=16'h8000.
  - Enum bp_cce_mode_e: e_cce_mode_uncached=0, e_cce_mode_normal=1.
  - FSM state enum bp_cfg_loader_state_e.
- Natural sub-module: bp_cfg_loader_counter, a clear/increment/max-compare counter. It is instantiated for both c and u.
- Everything else stays in the top FSM.

Test Plan:
- num_core_p=1, cce_pc_width_p=2, ready=1, ROM[i]=64'hA0+i. Required write sequence: (0,0x0002,1), (0,0x0004,0), 0x8000..0x8003 with data A0..A3, (0,0x0006,1), (0,0x0002,0). done_o rises 1 cycle after the last handshake, 15 cycles after reset deasserts.
- num_core_p=4, skip_ucode_p=1, ready=1:
  - 16 writes total.
  - core_id data = 0,1,2,3 in order.
  - 4 unfreezes to cores 0..3 come last.
  - cce_mode data = 0.
- Random back-pressure (ready 30% duty) on the first scenario. The write trace must be identical to the ready=1 trace, and outputs must hold stable whenever valid is high and ready is low.
- Assert reset_i during the 3rd microcode write, for 1 cycle. The next cycle must show cfg_v_o=0 and done_o=0; the full sequence then restarts from the freeze write to core 0.
- Hold ready=0 for 100 cycles at e_mode. cfg_v_o must stay 1 with constant addr 0x0006, and done_o must stay 0 until ready returns.
- After done_o=1, toggle cfg_ready_i for 50 cycles. cfg_v_o must remain 0 and done_o must remain 1.

Source files
------------

// File: rtl/bp_cfg_loader_pkg.sv
// bp_cfg_loader_pkg: shared config addresses, CCE mode and loader FSM state types
package bp_cfg_loader_pkg;
  localparam logic [15:0] freeze_addr     = 16'h0002;
  localparam logic [15:0] core_id_addr    = 16'h0004;
  localparam logic [15:0] cce_mode_addr   = 16'h0006;
  localparam logic [15:0] ucode_base_addr = 16'h8000;
  typedef enum logic [0:0] {
    e_cce_mode_uncached = 1'b0,
    e_cce_mode_normal   = 1'b1
  } bp_cce_mode_e;
  typedef enum logic [3:0] {
    e_reset,
    e_freeze,
    e_core_id,
    e_ucode_fetch,
    e_ucode_write,
    e_mode,
    e_next_core,
    e_unfreeze,
    e_done
  } bp_cfg_loader_state_e;
  function automatic logic is_write(bp_cfg_loader_state_e s);
    return s inside {e_freeze, e_core_id, e_ucode_write, e_mode, e_unfreeze};
  endfunction
endpackage

// File: rtl/bp_cfg_loader_counter.sv
// bp_cfg_loader_counter: clearable up-counter with a terminal-value flag
module bp_cfg_loader_counter #(
  parameter int width_p = 1,
  parameter int max_p   = 0
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               clr,
  input  logic               inc,
  output logic [width_p-1:0] count,
  output logic               is_max
);
  assign is_max = count == width_p'(max_p);
  // clear has priority over increment; wrap happens only through clr
  always_ff @(posedge clk)
    if (rst || clr) count <= '0;
    else if (inc) count <= count + width_p'(1);
endmodule

// File: rtl/bp_cfg_loader.sv
// bp_cfg_loader: post-reset sequencer writing freeze, id, microcode and mode to every core
module bp_cfg_loader
  import bp_cfg_loader_pkg::*;
#(
  parameter int num_core_p       = 1,
  parameter int cce_pc_width_p   = 8,
  parameter int cfg_addr_width_p = 16,
  parameter int cfg_data_width_p = 64,
  parameter bit skip_ucode_p     = 1'b0,
  localparam int core_w          = (num_core_p > 1) ? $clog2(num_core_p) : 1
) (
  input  logic                        clk_i,
  input  logic                        reset_i,
  output logic                        cfg_v_o,
  input  logic                        cfg_ready_i,
  output logic [core_w-1:0]           cfg_core_o,
  output logic [cfg_addr_width_p-1:0] cfg_addr_o,
  output logic [cfg_data_width_p-1:0] cfg_data_o,
  output logic [cce_pc_width_p-1:0]   ucode_addr_o,
  input  logic [cfg_data_width_p-1:0] ucode_data_i,
  output logic                        done_o
);
  bp_cfg_loader_state_e state, state_n;
  bp_cce_mode_e mode;
  logic hs, c_clr, c_inc, c_max, u_clr, u_inc, u_max;
  logic [core_w-1:0] c;
  logic [cce_pc_width_p-1:0] u;

  bp_cfg_loader_counter #(.width_p(core_w), .max_p(num_core_p - 1)) c_cnt (
    .clk(clk_i), .rst(reset_i), .clr(c_clr), .inc(c_inc), .count(c), .is_max(c_max)
  );
  bp_cfg_loader_counter #(.width_p(cce_pc_width_p), .max_p((1 << cce_pc_width_p) - 1)) u_cnt (
    .clk(clk_i), .rst(reset_i), .clr(u_clr), .inc(u_inc), .count(u), .is_max(u_max)
  );

  assign mode = skip_ucode_p ? e_cce_mode_uncached : e_cce_mode_normal;
  assign cfg_core_o = c;
  // during a ucode write the ROM is already addressed with the next word so it is ready when fetch captures it
  assign ucode_addr_o = (state == e_ucode_write && !u_max) ? u + cce_pc_width_p'(1) : u;

  // next-state and counter control; only registered signals and cfg_ready_i feed it
  always_comb begin
    hs = cfg_v_o & cfg_ready_i;
    c_clr = state == e_next_core && c_max;
    c_inc = (state == e_next_core && !c_max) || (state == e_unfreeze && hs && !c_max);
    u_clr = state == e_ucode_write && hs && u_max;
    u_inc = state == e_ucode_write && hs && !u_max;
    state_n = state;
    case (state)
      e_reset:       state_n = e_freeze;
      e_freeze:      state_n = hs ? e_core_id : state;
      e_core_id:     state_n = hs ? (skip_ucode_p ? e_mode : e_ucode_fetch) : state;
      e_ucode_fetch: state_n = e_ucode_write;
      e_ucode_write: state_n = hs ? (u_max ? e_mode : e_ucode_fetch) : state;
      e_mode:        state_n = hs ? e_next_core : state;
      e_next_core:   state_n = c_max ? e_unfreeze : e_freeze;
      e_unfreeze:    state_n = (hs && c_max) ? e_done : state;
      default:       state_n = state;
    endcase
  end

  // state plus registered bus outputs, loaded only on a state change so they hold under back-pressure
  always_ff @(posedge clk_i)
    if (reset_i) begin
      state      <= e_reset;
      cfg_v_o    <= 1'b0;
      done_o     <= 1'b0;
      cfg_addr_o <= '0;
      cfg_data_o <= '0;
    end else begin
      state <= state_n;
      if (state_n != state) begin
        cfg_v_o    <= is_write(state_n);
        done_o     <= state_n == e_done;
        cfg_addr_o <= state_n == e_core_id     ? cfg_addr_width_p'(core_id_addr)
                    : state_n == e_ucode_write ? cfg_addr_width_p'(ucode_base_addr) + cfg_addr_width_p'(u)
                    : state_n == e_mode        ? cfg_addr_width_p'(cce_mode_addr)
                    : is_write(state_n)        ? cfg_addr_width_p'(freeze_addr) : '0;
        cfg_data_o <= state_n == e_core_id     ? cfg_data_width_p'(c)
                    : state_n == e_ucode_write ? ucode_data_i
                    : state_n == e_mode        ? cfg_data_width_p'(mode)
                    : state_n == e_freeze      ? cfg_data_width_p'(1) : '0;
      end
    end
endmodule
